// File: rtl/alu_sequencer.sv
// Command-side driver for an external combinational 8-bit ALU: registers one command per
// handshake, captures the ALU result/flags, returns them on a response handshake, keeps an accumulator.
module alu_sequencer #(
    parameter int          CNT_W     = 16,
    parameter logic [7:0]  ACC_RESET = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic             cmd_use_acc,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_s,
    input  logic [7:0]       alu_r,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_r,
    output logic             rsp_c,
    output logic             rsp_v,
    output logic             rsp_z,
    output logic             rsp_err,
    output logic [7:0]       acc,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    logic               cmd_ready_q;
    logic               rsp_valid_q;
    logic [7:0]         alu_a_q;
    logic [7:0]         alu_b_q;
    logic [3:0]         alu_s_q;
    logic [7:0]         rsp_r_q;
    logic               rsp_c_q;
    logic               rsp_v_q;
    logic               rsp_z_q;
    logic               rsp_err_q;
    logic [7:0]         acc_q;
    logic [CNT_W-1:0]   op_count_q;
    logic               op_legal;

    // Select codes 0111..1110 are the only ones the ALU implements.
    assign op_legal = (alu_s_q >= 4'b0111) && (alu_s_q <= 4'b1110);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            alu_s_q     <= 4'h0;
            rsp_r_q     <= 8'h00;
            rsp_c_q     <= 1'b0;
            rsp_v_q     <= 1'b0;
            rsp_z_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
            acc_q       <= ACC_RESET;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        alu_s_q     <= cmd_op;
                        alu_b_q     <= cmd_b;
                        alu_a_q     <= cmd_use_acc ? acc_q : cmd_a;
                        cmd_ready_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_legal) begin
                        rsp_r_q    <= alu_r;
                        rsp_c_q    <= alu_c;
                        rsp_v_q    <= alu_v;
                        rsp_z_q    <= (alu_r == 8'h00);
                        rsp_err_q  <= 1'b0;
                        acc_q      <= alu_r;
                        op_count_q <= op_count_q + CNT_W'(1);
                    end else begin
                        rsp_r_q    <= 8'h00;
                        rsp_c_q    <= 1'b0;
                        rsp_v_q    <= 1'b0;
                        rsp_z_q    <= 1'b0;
                        rsp_err_q  <= 1'b1;
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    // cmd_ready rises only after this edge, so the next accept is a cycle later.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_v     = rsp_v_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_err   = rsp_err_q;
    assign acc       = acc_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer; a small behavioural ALU stands in for the real one.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Stand-in ALU: 1000 pass A, 1001 A-B, 1010 A+B, other legal codes A^B,
    // illegal codes drive junk (AA, c=1, v=1) so masking of illegal results is visible.
    function automatic logic [9:0] alu_model(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        logic [7:0] r;
        logic       c;
        logic       v;
        t = 9'd0;
        case (s)
            4'b1000: begin r = a; c = 1'b0; v = 1'b0; end
            4'b1001: begin
                t = {1'b0, a} + {1'b0, ~b} + 9'd1;
                r = t[7:0]; c = t[8]; v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'b1010: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[7:0]; c = t[8]; v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'b0111, 4'b1011, 4'b1100, 4'b1101, 4'b1110: begin r = a ^ b; c = 1'b0; v = 1'b0; end
            default: begin r = 8'hAA; c = 1'b1; v = 1'b1; end
        endcase
        return {c, v, r};
    endfunction

    // DUT 1: default parameters
    logic        cmd_valid, cmd_ready, cmd_use_acc;
    logic [3:0]  cmd_op, alu_s;
    logic [7:0]  cmd_a, cmd_b, alu_a, alu_b, alu_r, rsp_r, acc;
    logic        alu_c, alu_v, rsp_valid, rsp_ready, rsp_c, rsp_v, rsp_z, rsp_err;
    logic [15:0] op_count;

    assign {alu_c, alu_v, alu_r} = alu_model(alu_s, alu_a, alu_b);

    alu_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_r(alu_r), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_r(rsp_r), .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_z(rsp_z), .rsp_err(rsp_err),
        .acc(acc), .op_count(op_count)
    );

    // DUT 2: narrow counter for the wrap test
    logic        c2_valid, c2_ready, c2_use_acc;
    logic [3:0]  c2_op, a2_s;
    logic [7:0]  c2_a, c2_b, a2_a, a2_b, a2_r, r2_r, acc2;
    logic        a2_c, a2_v, r2_valid, r2_ready, r2_c, r2_v, r2_z, r2_err;
    logic [1:0]  op_count2;

    assign {a2_c, a2_v, a2_r} = alu_model(a2_s, a2_a, a2_b);

    alu_sequencer #(.CNT_W(2), .ACC_RESET(8'h00)) dut2 (
        .clk(clk), .rst(rst),
        .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_op(c2_op),
        .cmd_a(c2_a), .cmd_b(c2_b), .cmd_use_acc(c2_use_acc),
        .alu_a(a2_a), .alu_b(a2_b), .alu_s(a2_s),
        .alu_r(a2_r), .alu_c(a2_c), .alu_v(a2_v),
        .rsp_valid(r2_valid), .rsp_ready(r2_ready),
        .rsp_r(r2_r), .rsp_c(r2_c), .rsp_v(r2_v), .rsp_z(r2_z), .rsp_err(r2_err),
        .acc(acc2), .op_count(op_count2)
    );

    // One full transaction on DUT 1 with rsp_ready held high; ends at a negedge back in IDLE.
    task automatic do_op(input string name, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic use_acc, input logic [7:0] exp_a, input logic [7:0] exp_r,
                         input logic exp_c, input logic exp_v, input logic exp_z, input logic exp_err);
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc; cmd_valid = 1'b1; rsp_ready = 1'b1;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL %s cmd_ready: got %b want 1", name, cmd_ready); end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL %s early_rsp_valid: got %b want 0", name, rsp_valid); end
        checks++; if (alu_a !== exp_a) begin failures++; $display("FAIL %s alu_a: got %h want %h", name, alu_a, exp_a); end
        checks++; if (alu_s !== op) begin failures++; $display("FAIL %s alu_s: got %h want %h", name, alu_s, op); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL %s rsp_valid: got %b want 1", name, rsp_valid); end
        checks++; if (rsp_r !== exp_r) begin failures++; $display("FAIL %s rsp_r: got %h want %h", name, rsp_r, exp_r); end
        checks++; if ({rsp_c, rsp_v, rsp_z, rsp_err} !== {exp_c, exp_v, exp_z, exp_err})
            begin failures++; $display("FAIL %s flags cvze: got %b want %b", name, {rsp_c, rsp_v, rsp_z, rsp_err}, {exp_c, exp_v, exp_z, exp_err}); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            begin failures++; $display("FAIL %s return_idle: got valid=%b ready=%b want 0/1", name, rsp_valid, cmd_ready); end
        $display("op %s: s=%h a=%h b=%h -> r=%h c=%b v=%b z=%b err=%b acc=%h cnt=%0d",
                 name, op, alu_a, b, rsp_r, rsp_c, rsp_v, rsp_z, rsp_err, acc, op_count);
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_use_acc = 1'b0; rsp_ready = 1'b1;
        c2_valid = 1'b0; c2_op = 4'h0; c2_a = 8'h00; c2_b = 8'h00; c2_use_acc = 1'b0; r2_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
            begin failures++; $display("FAIL reset handshake: got ready=%b valid=%b want 1/0", cmd_ready, rsp_valid); end
        checks++; if ({alu_a, alu_b, alu_s} !== 20'h0)
            begin failures++; $display("FAIL reset alu_regs: got %h want 00000", {alu_a, alu_b, alu_s}); end
        checks++; if ({rsp_r, rsp_c, rsp_v, rsp_z, rsp_err} !== 12'h0)
            begin failures++; $display("FAIL reset rsp: got %h want 000", {rsp_r, rsp_c, rsp_v, rsp_z, rsp_err}); end
        checks++; if (acc !== 8'h00 || op_count !== 16'd0)
            begin failures++; $display("FAIL reset acc_cnt: got acc=%h cnt=%0d want 00/0", acc, op_count); end
        $display("reset: ready=%b valid=%b acc=%h cnt=%0d", cmd_ready, rsp_valid, acc, op_count);
    endtask

    task automatic test_add_overflow();
        do_op("add7F01", 4'b1010, 8'h7F, 8'h01, 1'b0, 8'h7F, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (acc !== 8'h80 || op_count !== 16'd1)
            begin failures++; $display("FAIL add7F01 acc_cnt: got acc=%h cnt=%0d want 80/1", acc, op_count); end
    endtask

    task automatic test_use_acc();
        // a=33 must be ignored; 80-80 = 00 with no borrow (carry out 1)
        do_op("sub_acc", 4'b1001, 8'h33, 8'h80, 1'b1, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++; if (acc !== 8'h00 || op_count !== 16'd2)
            begin failures++; $display("FAIL sub_acc acc_cnt: got acc=%h cnt=%0d want 00/2", acc, op_count); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_op = 4'b1010; cmd_a = 8'h10; cmd_b = 8'h20; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_op = 4'b1010; cmd_a = 8'hFF; cmd_b = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_r !== 8'h30 || rsp_v !== 1'b0)
                begin failures++; $display("FAIL hold%0d rsp: got valid=%b r=%h v=%b want 1/30/0", i, rsp_valid, rsp_r, rsp_v); end
            checks++; if (cmd_ready !== 1'b0 || alu_a !== 8'h10 || alu_b !== 8'h20)
                begin failures++; $display("FAIL hold%0d cmd: got ready=%b a=%h b=%h want 0/10/20", i, cmd_ready, alu_a, alu_b); end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || acc !== 8'h30 || op_count !== 16'd3)
            begin failures++; $display("FAIL hold release: got valid=%b acc=%h cnt=%0d want 0/30/3", rsp_valid, acc, op_count); end
        $display("backpressure: r=%h acc=%h cnt=%0d", rsp_r, acc, op_count);
    endtask

    task automatic test_illegal();
        do_op("ill1111", 4'b1111, 8'h12, 8'h34, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (acc !== 8'h30 || op_count !== 16'd3)
            begin failures++; $display("FAIL ill1111 acc_cnt: got acc=%h cnt=%0d want 30/3", acc, op_count); end
        do_op("ill0000", 4'b0000, 8'h12, 8'h34, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (acc !== 8'h30 || op_count !== 16'd3)
            begin failures++; $display("FAIL ill0000 acc_cnt: got acc=%h cnt=%0d want 30/3", acc, op_count); end
    endtask

    task automatic test_reset_in_exec();
        do_op("add5005", 4'b1010, 8'h50, 8'h05, 1'b0, 8'h50, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cmd_op = 4'b1010; cmd_a = 8'h01; cmd_b = 8'h01; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (acc !== 8'h00 || op_count !== 16'd0 || alu_a !== 8'h00)
            begin failures++; $display("FAIL rst_exec state: got acc=%h cnt=%0d a=%h want 00/0/00", acc, op_count, alu_a); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
                begin failures++; $display("FAIL rst_exec cyc%0d: got valid=%b ready=%b want 0/1", i, rsp_valid, cmd_ready); end
        end
        $display("reset_in_exec: valid=%b ready=%b acc=%h", rsp_valid, cmd_ready, acc);
    endtask

    task automatic test_count_wrap();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            c2_op = 4'b1000; c2_a = 8'(i); c2_b = 8'hC3; c2_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            c2_valid = 1'b0;
            @(negedge clk);
            checks++; if (r2_valid !== 1'b1 || r2_r !== 8'(i))
                begin failures++; $display("FAIL wrap op%0d: got valid=%b r=%h want 1/%h", i, r2_valid, r2_r, 8'(i)); end
            @(negedge clk);
            $display("wrap op%0d: r=%h acc=%h cnt=%0d", i, r2_r, acc2, op_count2);
        end
        checks++; if (op_count2 !== 2'd1 || acc2 !== 8'h05)
            begin failures++; $display("FAIL wrap final: got cnt=%0d acc=%h want 1/05", op_count2, acc2); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_use_acc();
        test_backpressure();
        test_illegal();
        test_reset_in_exec();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion want finish");
        $fatal(1, "timeout");
    end

endmodule
